// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset sequencer between clock wizard and SoC reset tree
// Releases periph_rst_o after lock is qualified, then core_rst_o; tracks reset cause and lock losses.
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 4,
  parameter int PERIPH_HOLD = 16,
  parameter int CORE_DELAY  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       locked_i,
  input  logic       sw_rst_req_i,
  output logic       periph_rst_o,
  output logic       core_rst_o,
  output logic       rst_done_o,
  output logic [1:0] rst_cause_o,
  output logic [2:0] state_o,
  output logic [7:0] lock_loss_cnt_o
);

  localparam int MAX_AB  = (LOCK_FILTER > PERIPH_HOLD) ? LOCK_FILTER : PERIPH_HOLD;
  localparam int MAX_CNT = (MAX_AB > CORE_DELAY) ? MAX_AB : CORE_DELAY;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;

  typedef enum logic [2:0] {
    S_WAIT_LOCK   = 3'd0,
    S_PERIPH_HOLD = 3'd1,
    S_CORE_HOLD   = 3'd2,
    S_RUN         = 3'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt, cnt_inc;
  logic [1:0]             cause_nxt;
  logic                   lock_loss;
  logic [SYNC_STAGES-1:0] rst_chain;
  logic [SYNC_STAGES-1:0] lock_chain;
  logic                   rst_sync;
  logic                   lock_s;

  assign rst_sync = rst_chain[SYNC_STAGES-1];
  assign lock_s   = lock_chain[SYNC_STAGES-1];
  assign cnt_inc  = cnt + CW'(1);
  assign state_o  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_chain  <= '0;
      lock_chain <= '0;
    end else begin
      rst_chain  <= {rst_chain[SYNC_STAGES-2:0], 1'b1};
      lock_chain <= {lock_chain[SYNC_STAGES-2:0], locked_i};
    end
  end

  // Lock loss has priority over a software request in the same cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cause_nxt = rst_cause_o;
    lock_loss = 1'b0;
    case (state)
      S_WAIT_LOCK: begin
        if (!rst_sync || !lock_s) begin
          cnt_nxt = '0;
        end else if (cnt_inc == CW'(LOCK_FILTER)) begin
          state_nxt = S_PERIPH_HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_PERIPH_HOLD, S_CORE_HOLD: begin
        if (!lock_s) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
          cause_nxt = CAUSE_LOCK;
          lock_loss = 1'b1;
        end else if ((state == S_PERIPH_HOLD) && (cnt_inc == CW'(PERIPH_HOLD))) begin
          state_nxt = S_CORE_HOLD;
          cnt_nxt   = '0;
        end else if ((state == S_CORE_HOLD) && (cnt_inc == CW'(CORE_DELAY))) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
          cause_nxt = CAUSE_LOCK;
          lock_loss = 1'b1;
        end else if (sw_rst_req_i) begin
          state_nxt = S_PERIPH_HOLD;
          cnt_nxt   = '0;
          cause_nxt = CAUSE_SW;
        end
      end
      default: begin
        state_nxt = S_WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs decode state_nxt so they move on the same edge as state_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_WAIT_LOCK;
      cnt             <= '0;
      rst_cause_o     <= CAUSE_POR;
      lock_loss_cnt_o <= 8'd0;
      periph_rst_o    <= 1'b1;
      core_rst_o      <= 1'b1;
      rst_done_o      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      rst_cause_o  <= cause_nxt;
      periph_rst_o <= (state_nxt == S_WAIT_LOCK) || (state_nxt == S_PERIPH_HOLD);
      core_rst_o   <= (state_nxt != S_RUN);
      rst_done_o   <= (state_nxt == S_RUN);
      if (lock_loss && (lock_loss_cnt_o != 8'hFF)) begin
        lock_loss_cnt_o <= lock_loss_cnt_o + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       rst_n;
  logic       locked_i;
  logic       sw_rst_req_i;
  logic       periph_rst_o;
  logic       core_rst_o;
  logic       rst_done_o;
  logic [1:0] rst_cause_o;
  logic [2:0] state_o;
  logic [7:0] lock_loss_cnt_o;

  int checks = 0;
  int passes = 0;

  reset_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .locked_i        (locked_i),
    .sw_rst_req_i    (sw_rst_req_i),
    .periph_rst_o    (periph_rst_o),
    .core_rst_o      (core_rst_o),
    .rst_done_o      (rst_done_o),
    .rst_cause_o     (rst_cause_o),
    .state_o         (state_o),
    .lock_loss_cnt_o (lock_loss_cnt_o)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; locked_i = 1'b1; sw_rst_req_i = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (periph_rst_o !== 1'b1) $display("FAIL reset_periph: got %b expected 1", periph_rst_o); else passes++;
    checks++; if (core_rst_o !== 1'b1) $display("FAIL reset_core: got %b expected 1", core_rst_o); else passes++;
    checks++; if (rst_done_o !== 1'b0) $display("FAIL reset_done: got %b expected 0", rst_done_o); else passes++;
    checks++; if (state_o !== 3'd0) $display("FAIL reset_state: got %0d expected 0", state_o); else passes++;
    checks++; if (rst_cause_o !== 2'b00) $display("FAIL reset_cause: got %b expected 00", rst_cause_o); else passes++;
    checks++; if (lock_loss_cnt_o !== 8'd0) $display("FAIL reset_cnt: got %0d expected 0", lock_loss_cnt_o); else passes++;
  endtask

  task automatic test_power_on;
    rst_n = 1'b1;
    tick(5);
    checks++; if (state_o !== 3'd0) $display("FAIL por_state_e5: got %0d expected 0", state_o); else passes++;
    tick(1);
    checks++; if (state_o !== 3'd1) $display("FAIL por_state_e6: got %0d expected 1", state_o); else passes++;
    tick(15);
    checks++; if (periph_rst_o !== 1'b1) $display("FAIL por_periph_e21: got %b expected 1", periph_rst_o); else passes++;
    tick(1);
    checks++; if (periph_rst_o !== 1'b0) $display("FAIL por_periph_e22: got %b expected 0", periph_rst_o); else passes++;
    checks++; if (state_o !== 3'd2) $display("FAIL por_state_e22: got %0d expected 2", state_o); else passes++;
    tick(7);
    checks++; if (core_rst_o !== 1'b1) $display("FAIL por_core_e29: got %b expected 1", core_rst_o); else passes++;
    tick(1);
    checks++; if (core_rst_o !== 1'b0) $display("FAIL por_core_e30: got %b expected 0", core_rst_o); else passes++;
    checks++; if (rst_done_o !== 1'b1) $display("FAIL por_done_e30: got %b expected 1", rst_done_o); else passes++;
    checks++; if (rst_cause_o !== 2'b00) $display("FAIL por_cause: got %b expected 00", rst_cause_o); else passes++;
  endtask

  task automatic test_lock_loss;
    locked_i = 1'b0;
    tick(2);
    checks++; if (state_o !== 3'd3) $display("FAIL ll_state_e2: got %0d expected 3", state_o); else passes++;
    tick(1);
    checks++; if (state_o !== 3'd0) $display("FAIL ll_state_e3: got %0d expected 0", state_o); else passes++;
    checks++; if ({periph_rst_o, core_rst_o, rst_done_o} !== 3'b110) $display("FAIL ll_resets: got %b expected 110", {periph_rst_o, core_rst_o, rst_done_o}); else passes++;
    checks++; if (rst_cause_o !== 2'b01) $display("FAIL ll_cause: got %b expected 01", rst_cause_o); else passes++;
    checks++; if (lock_loss_cnt_o !== 8'd1) $display("FAIL ll_cnt: got %0d expected 1", lock_loss_cnt_o); else passes++;
    locked_i = 1'b1;
    tick(6);
    checks++; if (state_o !== 3'd1) $display("FAIL ll_relock_e6: got %0d expected 1", state_o); else passes++;
    tick(16);
    checks++; if (periph_rst_o !== 1'b0) $display("FAIL ll_relock_periph: got %b expected 0", periph_rst_o); else passes++;
    tick(8);
    checks++; if (rst_done_o !== 1'b1) $display("FAIL ll_relock_done: got %b expected 1", rst_done_o); else passes++;
    checks++; if (rst_cause_o !== 2'b01) $display("FAIL ll_relock_cause: got %b expected 01", rst_cause_o); else passes++;
  endtask

  task automatic test_sw_reset;
    sw_rst_req_i = 1'b1;
    tick(1);
    sw_rst_req_i = 1'b0;
    checks++; if (state_o !== 3'd1) $display("FAIL sw_state: got %0d expected 1", state_o); else passes++;
    checks++; if ({periph_rst_o, core_rst_o} !== 2'b11) $display("FAIL sw_resets: got %b expected 11", {periph_rst_o, core_rst_o}); else passes++;
    checks++; if (rst_cause_o !== 2'b10) $display("FAIL sw_cause: got %b expected 10", rst_cause_o); else passes++;
    tick(15);
    checks++; if (periph_rst_o !== 1'b1) $display("FAIL sw_periph_15: got %b expected 1", periph_rst_o); else passes++;
    tick(1);
    checks++; if (periph_rst_o !== 1'b0) $display("FAIL sw_periph_16: got %b expected 0", periph_rst_o); else passes++;
    sw_rst_req_i = 1'b1;
    tick(1);
    sw_rst_req_i = 1'b0;
    checks++; if (state_o !== 3'd2) $display("FAIL sw_in_core_hold: got %0d expected 2", state_o); else passes++;
    tick(6);
    checks++; if (core_rst_o !== 1'b1) $display("FAIL sw_core_7: got %b expected 1", core_rst_o); else passes++;
    tick(1);
    checks++; if ({core_rst_o, rst_done_o} !== 2'b01) $display("FAIL sw_core_8: got %b expected 01", {core_rst_o, rst_done_o}); else passes++;
    checks++; if (lock_loss_cnt_o !== 8'd1) $display("FAIL sw_cnt: got %0d expected 1", lock_loss_cnt_o); else passes++;
  endtask

  task automatic test_simultaneous;
    locked_i = 1'b0;
    tick(2);
    sw_rst_req_i = 1'b1;
    tick(1);
    sw_rst_req_i = 1'b0;
    checks++; if (state_o !== 3'd0) $display("FAIL sim_state: got %0d expected 0", state_o); else passes++;
    checks++; if (rst_cause_o !== 2'b01) $display("FAIL sim_cause: got %b expected 01", rst_cause_o); else passes++;
    checks++; if (lock_loss_cnt_o !== 8'd2) $display("FAIL sim_cnt: got %0d expected 2", lock_loss_cnt_o); else passes++;
  endtask

  task automatic test_lock_filter;
    locked_i = 1'b1;
    tick(3);
    locked_i = 1'b0;
    tick(1);
    locked_i = 1'b1;
    tick(2);
    checks++; if (state_o !== 3'd0) $display("FAIL filt_glitch: got %0d expected 0", state_o); else passes++;
    tick(3);
    checks++; if (state_o !== 3'd0) $display("FAIL filt_3high: got %0d expected 0", state_o); else passes++;
    tick(1);
    checks++; if (state_o !== 3'd1) $display("FAIL filt_4high: got %0d expected 1", state_o); else passes++;
    tick(15);
    checks++; if (periph_rst_o !== 1'b1) $display("FAIL filt_periph_15: got %b expected 1", periph_rst_o); else passes++;
    tick(1);
    checks++; if (periph_rst_o !== 1'b0) $display("FAIL filt_periph_16: got %b expected 0", periph_rst_o); else passes++;
  endtask

  task automatic test_saturation;
    repeat (252) begin
      locked_i = 1'b1;
      tick(8);
      locked_i = 1'b0;
      tick(4);
    end
    checks++; if (lock_loss_cnt_o !== 8'd254) $display("FAIL sat_254: got %0d expected 254", lock_loss_cnt_o); else passes++;
    repeat (48) begin
      locked_i = 1'b1;
      tick(8);
      locked_i = 1'b0;
      tick(4);
    end
    checks++; if (lock_loss_cnt_o !== 8'd255) $display("FAIL sat_255: got %0d expected 255", lock_loss_cnt_o); else passes++;
  endtask

  task automatic test_async_reset;
    locked_i = 1'b1;
    tick(25);
    checks++; if (state_o !== 3'd2) $display("FAIL async_pre_state: got %0d expected 2", state_o); else passes++;
    clk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (state_o !== 3'd0) $display("FAIL async_state: got %0d expected 0", state_o); else passes++;
    checks++; if ({periph_rst_o, core_rst_o, rst_done_o} !== 3'b110) $display("FAIL async_resets: got %b expected 110", {periph_rst_o, core_rst_o, rst_done_o}); else passes++;
    checks++; if (rst_cause_o !== 2'b00) $display("FAIL async_cause: got %b expected 00", rst_cause_o); else passes++;
    checks++; if (lock_loss_cnt_o !== 8'd0) $display("FAIL async_cnt: got %0d expected 0", lock_loss_cnt_o); else passes++;
    #5;
    rst_n = 1'b1;
    clk_en = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_lock_loss();
    test_sw_reset();
    test_simultaneous();
    test_lock_filter();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Reset sequencer between the clock wizard and the SoC reset tree. It takes the board reset pin, the clock wizard `locked` flag and a software reset request, and produces staged, synchronously released active-high resets: peripheral subsystem first, core last. It reports the cause of the most recent reset and counts clock-lock losses.

## Interface
Parameters
- SYNC_STAGES, 2: synchronizer depth for `rst_n` deassertion and `locked_i`; minimum 2.
- LOCK_FILTER, 4: consecutive synchronized-high `locked` cycles required before the sequence starts; minimum 1.
- PERIPH_HOLD, 16: cycles `periph_rst_o` stays asserted after lock is qualified; minimum 1.
- CORE_DELAY, 8: cycles between `periph_rst_o` release and `core_rst_o` release; minimum 1.

Ports
- clk, in, 1: system clock (clock wizard `clk_out1`).
- rst_n, in, 1: board reset. Asynchronous, active-low.
- locked_i, in, 1: clock wizard lock. Asynchronous to `clk`.
- sw_rst_req_i, in, 1: single-cycle software reset request, synchronous to `clk`.
- periph_rst_o, out, 1: active-high reset for the peripheral subsystem.
- core_rst_o, out, 1: active-high reset for the core.
- rst_done_o, out, 1: sequence complete; system running.
- rst_cause_o, out, 2: cause of the last reset. 00 = pin/power-on, 01 = lock loss, 10 = software.
- state_o, out, 3: FSM state code, for debug.
- lock_loss_cnt_o, out, 8: saturating count of lock-loss events.

## Operation
Clock and reset
- One clock. Every flop is reset asynchronously by `rst_n` low.
- The internal `rst_sync` is a SYNC_STAGES-deep chain that shifts in 1 after `rst_n` rises.
- The FSM holds in WAIT_LOCK while `rst_sync` = 0.
- `locked_i` passes through a SYNC_STAGES-deep synchronizer (reset value 0) to give `lock_s`.

Reset values
- WAIT_LOCK state (code 0).
- `periph_rst_o` = 1, `core_rst_o` = 1, `rst_done_o` = 0.
- `rst_cause_o` = 00, `lock_loss_cnt_o` = 0, internal counter = 0.

FSM states (code)
- WAIT_LOCK (0): counter increments while `lock_s` = 1 and clears when `lock_s` = 0. Goes to PERIPH_HOLD on the edge where the counter would reach LOCK_FILTER. Counter clears on the transition.
- PERIPH_HOLD (1): counts PERIPH_HOLD cycles, then goes to CORE_HOLD.
- CORE_HOLD (2): counts CORE_DELAY cycles, then goes to RUN.
- RUN (3): runs until a lock loss or a software request.

Transitions out of the hold states and RUN
- Lock loss (`lock_s` = 0 in PERIPH_HOLD, CORE_HOLD or RUN): go to WAIT_LOCK, set `rst_cause_o` = 01, increment `lock_loss_cnt_o` (saturating at 255), clear the counter.
- Software request (`sw_rst_req_i` = 1 in RUN): go to PERIPH_HOLD and set `rst_cause_o` = 10.
- `sw_rst_req_i` is ignored in every other state and is not queued.
- If lock loss and `sw_rst_req_i` occur in the same cycle, lock loss wins and cause = 01.

Outputs
- All outputs are registered and decoded from the next state, so they change on the same edge as `state_o`.
- `periph_rst_o` = 1 in WAIT_LOCK and PERIPH_HOLD.
- `core_rst_o` = 1 in every state except RUN.
- `rst_done_o` = 1 only in RUN.

Counters
- The internal counter is clog2(max(LOCK_FILTER, PERIPH_HOLD, CORE_DELAY)+1) bits wide and never wraps.
- `lock_loss_cnt_o` is cleared only by `rst_n`.

## Timing
Edges are numbered from the first `clk` rising edge after `rst_n` rises, with `locked_i` already high and default parameters.
- `rst_sync` and `lock_s` are high after edge SYNC_STAGES (2).
- WAIT_LOCK → PERIPH_HOLD at edge SYNC_STAGES + LOCK_FILTER (6).
- `periph_rst_o` falls at edge 6 + PERIPH_HOLD (22).
- `core_rst_o` falls and `rst_done_o` rises at edge 22 + CORE_DELAY (30).

Event latencies
- Lock loss: outputs reassert on edge SYNC_STAGES + 1 (3) after `locked_i` falls.
- Software request: `periph_rst_o` and `core_rst_o` rise on the next edge. `periph_rst_o` falls PERIPH_HOLD edges later; `core_rst_o` falls CORE_DELAY edges after that.
- `rst_n` low mid-sequence: all outputs return to their reset values immediately, with no clock needed.
- `locked_i` glitches shorter than LOCK_FILTER cycles in WAIT_LOCK restart the filter from 0.

## Test plan
- Power-on: `rst_n` low for 5 cycles then high, `locked_i` = 1. `periph_rst_o` falls at edge 22; `core_rst_o` falls and `rst_done_o` rises at edge 30; `rst_cause_o` = 00.
- Lock filter: in WAIT_LOCK, `locked_i` high for 3 cycles, low for 1, then high. The sequence starts only after 4 consecutive `lock_s`-high cycles. `periph_rst_o` falls 4 + 16 edges after the final rise reaches `lock_s`.
- Lock loss in RUN: drop `locked_i`. Within 3 edges `periph_rst_o` = `core_rst_o` = 1, `state_o` = 0, `rst_cause_o` = 01, `lock_loss_cnt_o` = 1. Restore lock and the full sequence repeats.
- Software reset: 1-cycle `sw_rst_req_i` in RUN. Next edge `state_o` = 1 and both resets = 1; `periph_rst_o` is released 16 edges later and `core_rst_o` 8 edges after that; `rst_cause_o` = 10. A request issued during CORE_HOLD has no effect.
- Simultaneous events and saturation: `sw_rst_req_i` in the same cycle `lock_s` falls gives cause 01. 300 lock-loss events give `lock_loss_cnt_o` = 255.
- Async reset mid-sequence: `rst_n` low during CORE_HOLD with no clock toggling. All outputs take their reset values immediately and `lock_loss_cnt_o` = 0.
